// File: rtl/isqrt_rr_scheduler_if.sv
// isqrt_rr_scheduler_if: requester and response channels of the shared sqrt scheduler.
// master = user side (req_valid/req_operand/rsp_ready), slave = scheduler side.
interface isqrt_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_operand;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W/2-1:0]    rsp_root;
  logic [W/2:0]      rsp_rem;
  logic              rsp_err;

  modport master (
    output req_valid, req_operand, rsp_ready,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_root, rsp_rem, rsp_err
  );

  modport slave (
    input  req_valid, req_operand, rsp_ready,
    output req_ready, rsp_valid, rsp_id,
    output rsp_root, rsp_rem, rsp_err
  );
endinterface

// File: rtl/isqrt_rr_scheduler.sv
// isqrt_rr_scheduler: round-robin sharing of one multi-cycle isqrt engine.
// Ports: clk, rst (sync, active-high), bus (requests + response, slave),
//   eng_start/eng_operand -> engine, eng_done/eng_root/eng_rem <- engine, busy.
// Optional: define ISQRT_SCHED_WATCHDOG_EN for a WAIT timeout (TIMEOUT cycles).
module isqrt_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  isqrt_rr_scheduler_if.slave  bus,
  output logic                 eng_start,
  output logic [W-1:0]         eng_operand,
  input  logic                 eng_done,
  input  logic [W/2-1:0]       eng_root,
  input  logic [W/2:0]         eng_rem,
  output logic                 busy
);
  localparam int IDW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || (W % 2) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("isqrt_rr_scheduler: bad parameters");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, id_q, grant, rr_next;
  logic           found, accept, tmo;
  logic [W-1:0]   op_q;
  logic [W/2-1:0] root_q;
  logic [W/2:0]   rem_q;
  logic           err_q;
  logic [NREQ-1:0] ready_c;
  int             idx;

  // first valid requester at or after rr_q, wrapping
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!found && bus.req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        grant = idx[IDW-1:0];
      end
    end
  end

  assign accept  = (state_q == IDLE) && found && !rst;
  assign rr_next = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    ready_c = '0;
    if (accept) ready_c[grant] = 1'b1;
  end

`ifdef ISQRT_SCHED_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_q;

  // zero outside WAIT, so it is clear on every entry
  always_ff @(posedge clk) begin
    if (rst || state_q != WAIT) wd_q <= '0;
    else                        wd_q <= wd_q + 1'b1;
  end

  assign tmo = (state_q == WAIT) && (wd_q == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (found) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (eng_done || tmo) state_d = RESP;
      RESP:  if (bus.rsp_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      op_q    <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= bus.req_operand[grant*W +: W];
        id_q <= grant;
        rr_q <= rr_next;
      end
      if (state_q == WAIT) begin
        // done beats a same-cycle timeout
        if (eng_done) begin
          root_q <= eng_root;
          rem_q  <= eng_rem;
          err_q  <= 1'b0;
        end else if (tmo) begin
          root_q <= '0;
          rem_q  <= '0;
          err_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_root  = root_q;
  assign bus.rsp_rem   = rem_q;
  assign bus.rsp_err   = err_q;
  assign eng_start     = (state_q == ISSUE);
  assign eng_operand   = op_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: doc/isqrt_rr_scheduler.md
Name: isqrt_rr_scheduler

Overview:
Shares one multi-cycle integer square-root engine among NREQ requesters. Each requester uses a valid/ready handshake. A round-robin arbiter grants one request at a time. The block issues a one-cycle start pulse to the engine, waits for its done pulse, then returns the root, remainder and requester ID on a single shared response channel. It sits between the user-facing request logic and the sqrt datapath, and is the only block that drives the engine's start and operand inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, operand width in bits (even)
TIMEOUT, 16, watchdog limit in cycles while waiting for eng_done (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester request valid
req_operand  in  NREQ*W  packed operands; requester i occupies bits [i*W +: W]
req_ready  out  NREQ  per-requester accept, one-hot or zero
eng_start  out  1  one-cycle start pulse to the engine
eng_operand  out  W  operand to the engine; held stable from the start pulse until done
eng_done  in  1  engine completion pulse
eng_root  in  W/2  engine root result, valid while eng_done=1
eng_rem  in  W/2+1  engine remainder, valid while eng_done=1
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  clog2(NREQ)  index of the requester being answered
rsp_root  out  W/2  root result
rsp_rem  out  W/2+1  remainder result
rsp_err  out  1  timeout error flag (see Optional Feature)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr=0, and all outputs are 0 (req_ready, eng_start, eng_operand, rsp_valid, rsp_id, rsp_root, rsp_rem, rsp_err, busy). The engine shares rst. A reset in any state aborts the operation; no response is issued for the aborted request.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, …, wrapping modulo NREQ.
  - req_ready[grant]=1 combinationally; all other req_ready bits are 0. req_ready is 0 in every other state.
  - On a handshake: latch operand and ID, set rr_ptr = (grant+1) mod NREQ, go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE: eng_start=1 for exactly one cycle, eng_operand = latched operand. Go to WAIT.
- WAIT:
  - On eng_done=1: latch eng_root and eng_rem, set rsp_err=0, go to RESP.
  - eng_done pulses outside WAIT are ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_root, rsp_rem and rsp_err are held stable until rsp_ready=1.
  - On handshake: go to IDLE.
  - A new request can be accepted no earlier than the cycle after the response handshake (one idle bubble, by design).
- Minimum latency from req handshake to rsp_valid = 2 + engine latency, counted in cycles.
- Requesters drop req_valid only after a handshake. A requester that deasserts req_valid while waiting for grant is simply skipped.
- Fairness: with all requesters continuously valid, grants go 0,1,…,NREQ-1,0,… with no starvation.
- Width rules:
  - eng_operand equals the latched operand, unmodified.
  - Results are passed through unchanged. For a correct engine, rsp_root² + rsp_rem = operand.

Optional Feature:
- Macro: ISQRT_SCHED_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without eng_done: go to RESP with rsp_err=1, rsp_root=0, rsp_rem=0.
  - If eng_done and the timeout occur in the same cycle, eng_done wins (rsp_err=0).
- Not defined: no counter; rsp_err is tied to 0; WAIT holds indefinitely until eng_done.

Test Plan:
- Single request, engine model with 4-cycle latency: req0 operand 144 → rsp_id=0, root=12, rem=0; eng_start pulses exactly once. Operand 200 → root=14, rem=4.
- Boundary operands on req2: operand 0 → root=0, rem=0; operand 255 → root=15, rem=30.
- All four requesters held valid from reset, with operands 1, 4, 9, 16 → responses in order id 0,1,2,3 with roots 1,2,3,4. A fifth request from req0 is granted only after id 3 completes.
- Backpressure: hold rsp_ready=0 for 5 cycles during RESP → rsp_valid stays 1 with stable data, req_ready stays 0 throughout, and there is no second eng_start.
- rst asserted mid-WAIT, then a new request on req1 with operand 81 → no response for the aborted request; the next response is id=1, root=9, rem=0; rr_ptr restarts from 0.
- With ISQRT_SCHED_WATCHDOG_EN and TIMEOUT=16, engine never asserts done → rsp_valid rises after 16 WAIT cycles with rsp_err=1, root=0, rem=0. Without the macro, the same stimulus leaves busy=1 and rsp_valid=0 for 100 cycles.
